megadrive_pad_reader: RTL and testbench

Sequencer and decoder for Sega Mega Drive 3- and 6-button pads on the NeptUNO DB9 joystick ports. Sits downstream of `joydecoder`, which supplies the raw, de-serialised pin levels. Drives the shared pin-7 select line and walks the pad through its multiplexing phases. Delivers one coherent 12-bit button word per pad, plus presence and 6-button flags, to the `updater` message stage.

---
 rtl/megadrive_pad_pkg.sv | 59 +++++
 rtl/megadrive_pad_capture.sv | 162 ++++++++++++++++
 rtl/megadrive_pad_reader.sv | 142 ++++++++++++++
 tb/tb_megadrive_pad_reader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/megadrive_pad_pkg.sv
// -----------------------------------------------------------------------------
// megadrive_pad_pkg
//
// Shared definitions for the Mega Drive pad reader:
//   - state_e       : sequencer states IDLE, P0..P7
//   - BIT_*         : bit positions in the 12-bit button word (MXYZ SACB RLDU)
//   - PIN_*         : positions of the raw DB9 pins in the 6-bit pin vector
//                     {p9, p6, right, left, down, up}
//   - select_level(): level of the pin-7 select line while in a given state
//
// Optional feature macro used by the files that import this package:
//   MDPAD_SIX_BUTTON_EN - run the full P0..P7 sequence and decode X/Y/Z/Mode.
// -----------------------------------------------------------------------------
package megadrive_pad_pkg;

  typedef enum logic [3:0] {
    IDLE,
    P0,
    P1,
    P2,
    P3,
    P4,
    P5,
    P6,
    P7
  } state_e;

  localparam int BTN_W = 12;
  localparam int PIN_W = 6;

  // Button word bit positions.
  localparam int BIT_U = 0;
  localparam int BIT_D = 1;
  localparam int BIT_L = 2;
  localparam int BIT_R = 3;
  localparam int BIT_B = 4;
  localparam int BIT_C = 5;
  localparam int BIT_A = 6;
  localparam int BIT_S = 7;
  localparam int BIT_Z = 8;
  localparam int BIT_Y = 9;
  localparam int BIT_X = 10;
  localparam int BIT_M = 11;

  // Raw pin positions as delivered by the upstream de-serialiser.
  localparam int PIN_UP    = 0;
  localparam int PIN_DOWN  = 1;
  localparam int PIN_LEFT  = 2;
  localparam int PIN_RIGHT = 3;
  localparam int PIN_P6    = 4;
  localparam int PIN_P9    = 5;

  // Select is low only in the odd phases; IDLE keeps it high so that a
  // 6-button pad times out and restarts its internal phase counter.
  function automatic logic select_level(input state_e st);
    return !(st inside {P1, P3, P5, P7});
  endfunction

endpackage

// File: rtl/megadrive_pad_capture.sv
// -----------------------------------------------------------------------------
// megadrive_pad_capture
//
// One pad's worth of shadow registers and output registers. The shared
// sequencer tells it which phase is running, when the last cycle of a phase
// has arrived (sample_i) and when the sequence is complete (commit_i). Partial
// results live only in the shadow registers; the outputs change together on
// commit, so a half-read pad is never visible downstream.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   pins_i     in   raw pins {p9, p6, right, left, down, up}, active-low
//   phase_i    in   current sequencer state
//   sample_i   in   last cycle of the current phase
//   commit_i   in   last cycle of the final phase; load outputs
//   btn_o      out  buttons, active-high, MXYZ SACB RLDU
//   present_o  out  pad detected in the last sequence
//   six_o      out  6-button pad detected in the last sequence
//
// Configuration: MDPAD_SIX_BUTTON_EN enables the P5 identification and P6
// X/Y/Z/Mode capture; without it those registers do not exist.
// -----------------------------------------------------------------------------
module megadrive_pad_capture
  import megadrive_pad_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PIN_W-1:0] pins_i,
  input  state_e           phase_i,
  input  logic             sample_i,
  input  logic             commit_i,
  output logic [BTN_W-1:0] btn_o,
  output logic             present_o,
  output logic             six_o
);

`ifdef MDPAD_SIX_BUTTON_EN
  localparam int SH_W = 12;
`else
  localparam int SH_W = 8;
`endif

  logic [PIN_W-1:0] pressed;
  assign pressed = ~pins_i;

  logic [SH_W-1:0]  sh_btn_q, sh_btn_d;
  logic             sh_present_q, sh_present_d;
  logic [BTN_W-1:0] out_btn_q, out_btn_d;
  logic             out_present_q, out_present_d;

`ifdef MDPAD_SIX_BUTTON_EN
  logic sh_six_q, sh_six_d;
  logic out_six_q, out_six_d;
`endif

  // Shadow capture: each phase contributes its own slice of the word.
  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    sh_btn_d     = sh_btn_q;
    sh_present_d = sh_present_q;
`ifdef MDPAD_SIX_BUTTON_EN
    sh_six_d     = sh_six_q;
`endif
    if (sample_i) begin
      case (phase_i)
        P0: begin
          sh_btn_d[BIT_U] = pressed[PIN_UP];
          sh_btn_d[BIT_D] = pressed[PIN_DOWN];
          sh_btn_d[BIT_L] = pressed[PIN_LEFT];
          sh_btn_d[BIT_R] = pressed[PIN_RIGHT];
          sh_btn_d[BIT_B] = pressed[PIN_P6];
          sh_btn_d[BIT_C] = pressed[PIN_P9];
        end
        P1: begin
          sh_btn_d[BIT_A] = pressed[PIN_P6];
          sh_btn_d[BIT_S] = pressed[PIN_P9];
          // With select low a real pad grounds left and right; a floating
          // port reads them high.
          sh_present_d    = pressed[PIN_LEFT] & pressed[PIN_RIGHT];
        end
`ifdef MDPAD_SIX_BUTTON_EN
        P5: begin
          // Third low phase: a 6-button pad grounds all four directions.
          sh_six_d = &pressed[PIN_RIGHT:PIN_UP];
        end
        P6: begin
          sh_btn_d[BIT_Z] = pressed[PIN_UP];
          sh_btn_d[BIT_Y] = pressed[PIN_DOWN];
          sh_btn_d[BIT_X] = pressed[PIN_LEFT];
          sh_btn_d[BIT_M] = pressed[PIN_RIGHT];
        end
`endif
        default: ;
      endcase
    end
  end

  // Commit path reads the *_d shadow values: in the 3-button build the final
  // phase is also a sample phase, and its samples must make this commit.
  always_comb begin
    out_btn_d     = out_btn_q;
    out_present_d = out_present_q;
`ifdef MDPAD_SIX_BUTTON_EN
    out_six_d     = out_six_q;
`endif
    if (commit_i) begin
      out_present_d = sh_present_d;
`ifdef MDPAD_SIX_BUTTON_EN
      out_six_d     = sh_present_d & sh_six_d;
      if (!sh_present_d) begin
        out_btn_d = '0;
      end else if (sh_six_d) begin
        out_btn_d = sh_btn_d;
      end else begin
        out_btn_d = {4'b0000, sh_btn_d[BIT_S:BIT_U]};
      end
`else
      out_btn_d = sh_present_d ? {4'b0000, sh_btn_d} : '0;
`endif
    end
  end

  // NOTE: shadow registers are cleared on reset as well as the outputs, so an
  // abandoned sequence cannot leak stale samples into the next commit.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_btn_q      <= '0;
      sh_present_q  <= 1'b0;
      out_btn_q     <= '0;
      out_present_q <= 1'b0;
    end else begin
      sh_btn_q      <= sh_btn_d;
      sh_present_q  <= sh_present_d;
      out_btn_q     <= out_btn_d;
      out_present_q <= out_present_d;
    end
  end

`ifdef MDPAD_SIX_BUTTON_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_six_q  <= 1'b0;
      out_six_q <= 1'b0;
    end else begin
      sh_six_q  <= sh_six_d;
      out_six_q <= out_six_d;
    end
  end

  assign six_o = out_six_q;
`else
  assign six_o = 1'b0;
`endif

  assign btn_o     = out_btn_q;
  assign present_o = out_present_q;

endmodule

// File: rtl/megadrive_pad_reader.sv
// -----------------------------------------------------------------------------
// megadrive_pad_reader
//
// Sequencer and decoder for two Mega Drive 3/6-button pads sharing one pin-7
// select line. A single down-counter times every state: IDLE holds select high
// long enough for 6-button pads to reset, then each phase Pn lasts
// STEP_CYCLES. The last cycle of each phase is the only sample point; the last
// cycle of the final phase commits both pads and raises valid_o one cycle
// later together with the new outputs.
//
// Parameters:
//   STEP_CYCLES  clk cycles per select phase (>= 2)
//   IDLE_CYCLES  clk cycles of select high between sequences (>= 2)
//
// Ports:
//   clk              in   system clock
//   rst              in   synchronous active-high reset
//   joy1_raw_i       in   pad 1 raw pins {p9, p6, right, left, down, up}, active-low
//   joy2_raw_i       in   pad 2 raw pins, same order and polarity
//   joyp7_o          out  registered select line shared by both pads
//   joy1_o, joy2_o   out  button words, active-high, MXYZ SACB RLDU
//   joyN_present_o   out  pad detected in the last sequence
//   joyN_6btn_o      out  6-button pad detected in the last sequence
//   valid_o          out  one-cycle pulse when all outputs were just updated
//
// Configuration: MDPAD_SIX_BUTTON_EN selects the full IDLE->P0..P7 sequence;
// without it the sequence is IDLE->P0->P1 and commits at the end of P1.
// -----------------------------------------------------------------------------
module megadrive_pad_reader
  import megadrive_pad_pkg::*;
#(
  parameter int STEP_CYCLES = 1000,
  parameter int IDLE_CYCLES = 200000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIN_W-1:0] joy1_raw_i,
  input  logic [PIN_W-1:0] joy2_raw_i,
  output logic             joyp7_o,
  output logic [BTN_W-1:0] joy1_o,
  output logic [BTN_W-1:0] joy2_o,
  output logic             joy1_present_o,
  output logic             joy2_present_o,
  output logic             joy1_6btn_o,
  output logic             joy2_6btn_o,
  output logic             valid_o
);

  // The counter only ever holds (length - 1), so clog2 of the longest state
  // is wide enough.
  localparam int CNT_MAX = (IDLE_CYCLES > STEP_CYCLES) ? IDLE_CYCLES : STEP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(STEP_CYCLES - 1);

`ifdef MDPAD_SIX_BUTTON_EN
  localparam state_e LAST_PHASE = P7;
`else
  localparam state_e LAST_PHASE = P1;
`endif

  if (STEP_CYCLES < 2 || IDLE_CYCLES < 2) begin : g_bad_params
    $error("megadrive_pad_reader: STEP_CYCLES and IDLE_CYCLES must be >= 2");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             joyp7_q;
  logic             valid_q;
  logic             phase_done;
  logic             sample;
  logic             commit;

  assign phase_done = (cnt_q == '0);
  assign sample     = phase_done && (state_q != IDLE);
  assign commit     = phase_done && (state_q == LAST_PHASE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CNT_W'(1);
    if (phase_done) begin
      case (state_q)
        IDLE: state_d = P0;
        P0:   state_d = P1;
`ifdef MDPAD_SIX_BUTTON_EN
        P1:   state_d = P2;
        P2:   state_d = P3;
        P3:   state_d = P4;
        P4:   state_d = P5;
        P5:   state_d = P6;
        P6:   state_d = P7;
`endif
        default: state_d = IDLE;
      endcase
      cnt_d = (state_d == IDLE) ? IDLE_LOAD : STEP_LOAD;
    end
  end

  // Select is derived from the next state so that it changes on the first
  // cycle of each phase, straight out of a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= IDLE_LOAD;
      joyp7_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      joyp7_q <= select_level(state_d);
      valid_q <= commit;
    end
  end

  megadrive_pad_capture u_pad1 (
    .clk       (clk),
    .rst       (rst),
    .pins_i    (joy1_raw_i),
    .phase_i   (state_q),
    .sample_i  (sample),
    .commit_i  (commit),
    .btn_o     (joy1_o),
    .present_o (joy1_present_o),
    .six_o     (joy1_6btn_o)
  );

  megadrive_pad_capture u_pad2 (
    .clk       (clk),
    .rst       (rst),
    .pins_i    (joy2_raw_i),
    .phase_i   (state_q),
    .sample_i  (sample),
    .commit_i  (commit),
    .btn_o     (joy2_o),
    .present_o (joy2_present_o),
    .six_o     (joy2_6btn_o)
  );

  assign joyp7_o = joyp7_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_megadrive_pad_reader.sv
// -----------------------------------------------------------------------------
// tb_megadrive_pad_reader
//
// Bench for megadrive_pad_reader with STEP_CYCLES=4, IDLE_CYCLES=16. Two
// behavioural pads react to the select line the way real 3- and 6-button
// pads do (counting select falls, timing out after a long high). Expected
// words come from the pad type and pressed buttons, not from pin timing.
// Follows MDPAD_SIX_BUTTON_EN for the expected period and masking.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_megadrive_pad_reader;

  localparam int STEP = 4;
  localparam int IDLE = 16;
`ifdef MDPAD_SIX_BUTTON_EN
  localparam bit SIX  = 1'b1;
  localparam int NPH  = 8;
`else
  localparam bit SIX  = 1'b0;
  localparam int NPH  = 2;
`endif
  localparam int PERIOD = IDLE + NPH * STEP;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  joy1_raw, joy2_raw;
  logic        joyp7_o;
  logic [11:0] joy1_o, joy2_o;
  logic        joy1_present_o, joy2_present_o;
  logic        joy1_6btn_o, joy2_6btn_o;
  logic        valid_o;

  always #5 clk = ~clk;

  megadrive_pad_reader #(
    .STEP_CYCLES (STEP),
    .IDLE_CYCLES (IDLE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .joy1_raw_i     (joy1_raw),
    .joy2_raw_i     (joy2_raw),
    .joyp7_o        (joyp7_o),
    .joy1_o         (joy1_o),
    .joy2_o         (joy2_o),
    .joy1_present_o (joy1_present_o),
    .joy2_present_o (joy2_present_o),
    .joy1_6btn_o    (joy1_6btn_o),
    .joy2_6btn_o    (joy2_6btn_o),
    .valid_o        (valid_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Pad configuration: type 0 = absent, 1 = 3-button, 2 = 6-button.
  int          ptype1 = 0, ptype2 = 0;
  logic [11:0] btn1 = '0, btn2 = '0;

  logic [5:0] pins1 = 6'h3F, pins2 = 6'h3F;
  logic [5:0] glitch1 = '0, glitch2 = '0;
  bit         glitch_en = 1'b0;
  int         glitch_base = 0;

  assign joy1_raw = pins1 ^ glitch1;
  assign joy2_raw = pins2 ^ glitch2;

  // ---------------------------------------------------------------------------
  // Behavioural pad: drives pins from button state, select level and the
  // number of select falls since the last long high period.
  // ---------------------------------------------------------------------------
  int   falls   = 0;
  int   hi_run  = 100;
  logic prev_sel = 1'b1;

  function automatic logic [5:0] pad_pins(input int t, input logic [11:0] b,
                                          input logic sel, input int f);
    logic [5:0] p; // pressed view {p9, p6, right, left, down, up}
    if (t == 0) return 6'h3F;
    if (sel === 1'b1) begin
      if (t == 2 && f == 3) p = {b[5], b[4], b[11], b[10], b[9], b[8]};
      else                  p = {b[5], b[4], b[3], b[2], b[1], b[0]};
    end else begin
      if (t == 2 && f == 3)      p = {b[7], b[6], 4'hF};
      else if (t == 2 && f == 4) p = {b[7], b[6], 4'h0};
      else                       p = {b[7], b[6], 1'b1, 1'b1, b[1], b[0]};
    end
    return ~p;
  endfunction

  always @(negedge clk) begin
    if (joyp7_o === 1'b0 && prev_sel === 1'b1)
      falls = (hi_run > 8) ? 1 : falls + 1;
    if (joyp7_o === 1'b1) hi_run++;
    else                  hi_run = 0;
    prev_sel = joyp7_o;
    pins1 = pad_pins(ptype1, btn1, joyp7_o, falls);
    pins2 = pad_pins(ptype2, btn2, joyp7_o, falls);
  end

  // ---------------------------------------------------------------------------
  // Reference model: what a committed sequence should report for a pad.
  // ---------------------------------------------------------------------------
  function automatic logic [11:0] exp_word(input int t, input logic [11:0] b);
    if (t == 0) return 12'h000;
    if (t == 2 && SIX) return b;
    return {4'h0, b[7:0]};
  endfunction

  function automatic logic exp_sel(input int k);
    if (k < IDLE) return 1'b1;
    return (((k - IDLE) / STEP) % 2) == 0;
  endfunction

  // Offset within a period (0 = commit-pulse cycle) of a phase's last cycle.
  function automatic bit is_sample(input int o);
    if (o == IDLE + 1 * STEP - 1) return 1'b1;
    if (o == IDLE + 2 * STEP - 1) return 1'b1;
    if (SIX && o == IDLE + 6 * STEP - 1) return 1'b1;
    if (SIX && o == IDLE + 7 * STEP - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [11:0] rand_btn();
    logic [11:0] b;
    b = 12'($urandom);
    if (b[0] && b[1]) b[1] = 1'b0; // a d-pad cannot press up and down
    if (b[2] && b[3]) b[3] = 1'b0; // nor left and right
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (glitch_en && !is_sample((cyc - glitch_base) % PERIOD)) begin
      glitch1 = 6'($urandom);
      glitch2 = 6'($urandom);
    end else begin
      glitch1 = '0;
      glitch2 = '0;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (valid_o !== 1'b1 && n < PERIOD + 4);
    if (valid_o !== 1'b1) n = -1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_p7"},   joyp7_o, 1);
    check({tag, "_j1"},   joy1_o, 0);
    check({tag, "_j2"},   joy2_o, 0);
    check({tag, "_pr1"},  joy1_present_o, 0);
    check({tag, "_pr2"},  joy2_present_o, 0);
    check({tag, "_6b1"},  joy1_6btn_o, 0);
    check({tag, "_6b2"},  joy2_6btn_o, 0);
    check({tag, "_vld"},  valid_o, 0);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_j1"},  joy1_o, exp_word(ptype1, btn1));
    check({tag, "_j2"},  joy2_o, exp_word(ptype2, btn2));
    check({tag, "_pr1"}, joy1_present_o, ptype1 != 0);
    check({tag, "_pr2"}, joy2_present_o, ptype2 != 0);
    check({tag, "_6b1"}, joy1_6btn_o, SIX && ptype1 == 2);
    check({tag, "_6b2"}, joy2_6btn_o, SIX && ptype2 == 2);
  endtask

  // ---------------------------------------------------------------------------
  typedef struct {
    int          t1;
    logic [11:0] b1;
    int          t2;
    logic [11:0] b2;
    logic [11:0] e1;
    logic        p1;
    logic        s1;
    logic [11:0] e2;
    logic        p2;
    logic        s2;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    int sel_err;
    int early;
    int target;

    // Up+A 3-button, pad 2 absent.
    vecs[0] = '{1, 12'h041, 0, 12'h000, 12'h041, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0};
    // X+Mode+Start 6-button; Right+B+C 3-button.
    vecs[1] = '{2, 12'hC80, 1, 12'h038, SIX ? 12'hC80 : 12'h080, 1'b1, SIX,
                12'h038, 1'b1, 1'b0};
    // Z+Y+C 6-button; Down+Left+A+Start 6-button.
    vecs[2] = '{2, 12'h320, 2, 12'h0C6, SIX ? 12'h320 : 12'h020, 1'b1, SIX,
                12'h0C6, 1'b1, SIX};
    // Both ports empty.
    vecs[3] = '{0, 12'hFFF, 0, 12'h000, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};
    // 3-button has no upper buttons; 6-button with only X.
    vecs[4] = '{1, 12'hF81, 2, 12'h400, 12'h081, 1'b1, 1'b0,
                SIX ? 12'h400 : 12'h000, 1'b1, SIX};

    // ---- reset values and first sequence timing ----
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    check_cleared("reset");

    sel_err = 0;
    early   = 0;
    for (int k = 1; k < PERIOD; k++) begin
      tick();
      if (joyp7_o !== exp_sel(k)) sel_err++;
      if (valid_o !== 1'b0) early++;
    end
    tick();
    check("sel_walk_errors", sel_err, 0);
    check("early_valid", early, 0);
    check("first_valid_at_period", valid_o, 1);
    check_model("first");

    // ---- table vectors ----
    for (int i = 0; i < 5; i++) begin
      ptype1 = vecs[i].t1; btn1 = vecs[i].b1;
      ptype2 = vecs[i].t2; btn2 = vecs[i].b2;
      wait_valid(n);
      check($sformatf("v%0d_period", i), n, PERIOD);
      check($sformatf("v%0d_j1", i),  joy1_o, vecs[i].e1);
      check($sformatf("v%0d_pr1", i), joy1_present_o, vecs[i].p1);
      check($sformatf("v%0d_6b1", i), joy1_6btn_o, vecs[i].s1);
      check($sformatf("v%0d_j2", i),  joy2_o, vecs[i].e2);
      check($sformatf("v%0d_pr2", i), joy2_present_o, vecs[i].p2);
      check($sformatf("v%0d_6b2", i), joy2_6btn_o, vecs[i].s2);
    end

    // ---- pins toggled everywhere except on sample cycles ----
    ptype1 = 2; btn1 = 12'h4D5;
    ptype2 = 1; btn2 = 12'h0A6;
    wait_valid(n);
    check("preglitch_period", n, PERIOD);
    check_model("preglitch");
    glitch_base = cyc;
    glitch_en   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_valid(n);
      check($sformatf("glitch%0d_period", i), n, PERIOD);
      check_model($sformatf("glitch%0d", i));
    end
    glitch_en = 1'b0;

    // ---- reset in the middle of a sequence ----
    target = cyc + IDLE + (SIX ? 3 : 1) * STEP + 1;
    while (cyc < target) tick();
    check("midseq_sel_low", joyp7_o, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_cleared("midrst");
    wait_valid(n);
    check("midrst_restart_period", n, PERIOD);
    check_model("midrst");

    // ---- randomised pads ----
    for (int i = 0; i < 20; i++) begin
      ptype1 = $urandom_range(0, 2); btn1 = rand_btn();
      ptype2 = $urandom_range(0, 2); btn2 = rand_btn();
      wait_valid(n);
      check($sformatf("rnd%0d_period", i), n, PERIOD);
      check_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
